// File: rtl/code_lock_param.sv
// code_lock_param: parametrised sequential code lock with fail lockout; optional runtime programming via CODE_LOCK_PROG_EN
module code_lock_param #(
  parameter int CODE_LEN = 6,
  parameter int DIGIT_W = 4,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 64,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h590981
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               insere,
  input  logic [DIGIT_W-1:0] numero,
  input  logic               programa,
  output logic               LED,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               D,
  output logic               E,
  output logic               F,
  output logic               G,
  output logic               erro,
  output logic               bloqueado
);
  localparam int CW = CODE_LEN * DIGIT_W;
  localparam int IW = CODE_LEN > 1 ? $clog2(CODE_LEN) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);
  localparam logic [IW-1:0] LAST = IW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);

`ifdef CODE_LOCK_PROG_EN
  typedef enum logic [1:0] {ENTRY, OPEN, LOCKED, PROG} state_t;
`else
  typedef enum logic [1:0] {ENTRY, OPEN, LOCKED} state_t;
`endif

  state_t        state;
  logic [IW-1:0] idx;
  logic          mism;
  logic [FW-1:0] fails;
  logic [TW-1:0] timer;
  logic [CW-1:0] code;
  logic          insere_d;
  logic [6:0]    seg;
  logic          accept;
  logic          miss;
  logic [DIGIT_W-1:0] expd;
  logic [FW-1:0] fails_inc;
  logic [6:0]    segd;

`ifndef CODE_LOCK_PROG_EN
  logic unused_prog;
  assign unused_prog = programa;
  assign code = DEFAULT_CODE;
`endif

  assign {A, B, C, D, E, F, G} = seg;

  // Strobe qualification, expected digit for the current slot and mismatch accumulation
  always_comb begin
    accept = insere & ~insere_d & (32'(numero) < 32'd10);
    expd = code[(CODE_LEN - 1 - int'(idx)) * DIGIT_W +: DIGIT_W];
    miss = mism | (numero != expd);
    fails_inc = fails == FMAX ? FMAX : fails + 1'b1;
  end

  // Seven-segment decode of the incoming digit, A in the MSB
  always_comb begin
    case (numero)
      4'd0:    segd = 7'b1111110;
      4'd1:    segd = 7'b0110000;
      4'd2:    segd = 7'b1101101;
      4'd3:    segd = 7'b1111001;
      4'd4:    segd = 7'b0110011;
      4'd5:    segd = 7'b1011011;
      4'd6:    segd = 7'b1011111;
      4'd7:    segd = 7'b1110000;
      4'd8:    segd = 7'b1111111;
      4'd9:    segd = 7'b1111011;
      default: segd = 7'b0000000;
    endcase
  end

  // Lock FSM with registered outputs; all CODE_LEN digits are consumed before judging an attempt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ENTRY;
      idx <= '0;
      mism <= 1'b0;
      fails <= '0;
      timer <= '0;
      insere_d <= 1'b0;
      seg <= '0;
      LED <= 1'b0;
      erro <= 1'b0;
      bloqueado <= 1'b0;
`ifdef CODE_LOCK_PROG_EN
      code <= DEFAULT_CODE;
`endif
    end else begin
      insere_d <= insere;
      erro <= 1'b0;
      case (state)
        ENTRY: if (accept) begin
          seg <= segd;
          if (idx == LAST) begin
            idx <= '0;
            mism <= 1'b0;
            if (!miss) begin
              state <= OPEN;
              LED <= 1'b1;
              fails <= '0;
            end else begin
              erro <= 1'b1;
              fails <= fails_inc;
              if (fails_inc == FMAX) begin
                state <= LOCKED;
                timer <= TW'(LOCK_CYCLES);
                bloqueado <= 1'b1;
              end
            end
          end else begin
            idx <= idx + 1'b1;
            mism <= miss;
          end
        end
        OPEN: if (accept) begin
          seg <= segd;
          idx <= IW'(1);
          mism <= numero != expd;
          LED <= 1'b0;
          state <= ENTRY;
`ifdef CODE_LOCK_PROG_EN
          if (programa) begin
            state <= PROG;
            LED <= 1'b1;
            code[(CODE_LEN - 1) * DIGIT_W +: DIGIT_W] <= numero;
          end
`endif
        end
        LOCKED: begin
          timer <= timer - 1'b1;
          if (timer == TW'(1)) begin
            state <= ENTRY;
            bloqueado <= 1'b0;
            fails <= '0;
          end
        end
`ifdef CODE_LOCK_PROG_EN
        PROG: if (accept) begin
          seg <= segd;
          code[(CODE_LEN - 1 - int'(idx)) * DIGIT_W +: DIGIT_W] <= numero;
          if (idx == LAST) begin
            state <= ENTRY;
            LED <= 1'b0;
            fails <= '0;
            idx <= '0;
            mism <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif
        default: state <= ENTRY;
      endcase
    end
  end
endmodule

// File: tb/tb_code_lock_param.sv
// tb_code_lock_param: directed self-checking bench for code_lock_param
module tb_code_lock_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic insere = 1'b0;
  logic [3:0] numero = 4'd0;
  logic programa = 1'b0;
  logic LED, A, B, C, D, E, F, G, erro, bloqueado;
  logic [6:0] seg;
  int errors = 0;
  int checks = 0;
  int erro_cnt = 0;
  int bloq_cnt = 0;
  int base;

  assign seg = {A, B, C, D, E, F, G};

  code_lock_param dut (
    .clk(clk), .reset(reset), .insere(insere), .numero(numero), .programa(programa),
    .LED(LED), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .erro(erro), .bloqueado(bloqueado)
  );

  always #5 clk = ~clk;

  // Count cycles in which the pulse/level outputs are high
  always @(negedge clk) begin
    if (erro === 1'b1) erro_cnt++;
    if (bloqueado === 1'b1) bloq_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic strobe(input logic [3:0] d);
    @(negedge clk);
    numero = d;
    insere = 1'b1;
    @(negedge clk);
    insere = 1'b0;
  endtask

  task automatic enter(input logic [23:0] c);
    for (int i = 5; i >= 0; i--) strobe(c[i*4 +: 4]);
  endtask

  initial begin
    #3 reset = 1'b0;
    #1;
    chk("rst_led", 32'(LED), 0);
    chk("rst_seg", 32'(seg), 0);
    chk("rst_erro", 32'(erro), 0);
    chk("rst_bloq", 32'(bloqueado), 0);
    @(negedge clk);
    reset = 1'b1;

    base = erro_cnt;
    enter(24'h590981);
    chk("open_led", 32'(LED), 1);
    chk("open_seg", 32'(seg), 32'b0110000);
    @(negedge clk);
    chk("open_no_erro", 32'(erro_cnt - base), 0);

    strobe(4'd5);
    chk("reentry_led_drop", 32'(LED), 0);
    strobe(4'd9); strobe(4'd0); strobe(4'd9); strobe(4'd8); strobe(4'd2);
    chk("wrong_erro_hi", 32'(erro), 1);
    chk("wrong_led", 32'(LED), 0);
    chk("wrong_seg", 32'(seg), 32'b1101101);
    @(negedge clk);
    chk("wrong_erro_lo", 32'(erro), 0);

    enter(24'h111111);
    chk("fail2_bloq", 32'(bloqueado), 0);
    base = bloq_cnt;
    enter(24'h111111);
    chk("lock_bloq", 32'(bloqueado), 1);
    strobe(4'd7);
    chk("lock_seg_hold", 32'(seg), 32'b0110000);
    chk("lock_still", 32'(bloqueado), 1);
    for (int i = 0; i < 200 && bloqueado; i++) @(negedge clk);
    chk("lock_release", 32'(bloqueado), 0);
    chk("lock_cycles", 32'(bloq_cnt - base), 64);
    enter(24'h590981);
    chk("post_lock_open", 32'(LED), 1);

    @(negedge clk);
    numero = 4'd3;
    insere = 1'b1;
    repeat (10) @(negedge clk);
    insere = 1'b0;
    chk("hold_seg", 32'(seg), 32'b1111001);
    chk("hold_led", 32'(LED), 0);
    strobe(4'b1010);
    chk("invalid_seg", 32'(seg), 32'b1111001);
    base = erro_cnt;
    strobe(4'd9); strobe(4'd0); strobe(4'd9); strobe(4'd8);
    @(negedge clk);
    chk("hold_single_digit", 32'(erro_cnt - base), 0);
    strobe(4'd1);
    chk("hold_sixth_erro", 32'(erro), 1);
    chk("hold_sixth_led", 32'(LED), 0);

    strobe(4'd5); strobe(4'd9); strobe(4'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_led", 32'(LED), 0);
    chk("async_seg", 32'(seg), 0);
    chk("async_erro", 32'(erro), 0);
    chk("async_bloq", 32'(bloqueado), 0);
    @(negedge clk);
    reset = 1'b1;
    strobe(4'd9); strobe(4'd8); strobe(4'd1);
    chk("partial_no_open", 32'(LED), 0);
    strobe(4'd5); strobe(4'd9); strobe(4'd0);
    chk("partial_fails", 32'(erro), 1);
    enter(24'h590981);
    chk("fresh_open", 32'(LED), 1);

`ifdef CODE_LOCK_PROG_EN
    programa = 1'b1;
    strobe(4'd1);
    chk("prog_led", 32'(LED), 1);
    programa = 1'b0;
    strobe(4'd2); strobe(4'd3); strobe(4'd4); strobe(4'd5); strobe(4'd6);
    chk("prog_done_led", 32'(LED), 0);
    enter(24'h590981);
    chk("old_code_erro", 32'(erro), 1);
    chk("old_code_led", 32'(LED), 0);
    enter(24'h123456);
    chk("new_code_led", 32'(LED), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    enter(24'h590981);
    chk("default_after_rst", 32'(LED), 1);
`else
    programa = 1'b1;
    strobe(4'd1);
    chk("prog_ignored_led", 32'(LED), 0);
    programa = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
